// File: rtl/fibonacci_arbiter.sv
// Round-robin front end that shares one fibonacci core among N_REQ requesters,
// sequencing the core handshake and returning a result or an error per request.
module fibonacci_arbiter #(
    parameter int N_REQ       = 4,
    parameter int IDX_W       = 5,
    parameter int DATA_W      = 20,
    parameter int MAX_IDX     = 30,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*IDX_W-1:0]   req_idx_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic                     fib_start_o,
    output logic [IDX_W-1:0]         fib_idx_o,
    input  logic                     fib_ready_i,
    input  logic                     fib_done_i,
    input  logic [DATA_W-1:0]        fib_f_i
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   grant_r;
    logic [IDX_W-1:0]   idx_r;
    logic [TMR_W-1:0]   timer_r;
    logic [N_REQ-1:0]   rsp_valid_r;
    logic [DATA_W-1:0]  data_r;
    logic               err_r;

    logic [PTR_W:0]     pick_s;
    logic               grant_vld_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [IDX_W-1:0]   req_idx_sel_s;
    logic               bad_idx_s;
    logic               timeout_s;
    logic               rsp_fire_s;

    // Scan downward so the requester closest to ptr (lowest offset) wins.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int             cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (vld[PTR_W'(cand)]) begin
                res = {1'b1, PTR_W'(cand)};
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] k);
        logic [N_REQ-1:0] res;
        res    = '0;
        res[k] = 1'b1;
        return res;
    endfunction

    assign pick_s        = rr_pick(req_valid_i, rr_ptr_r);
    assign grant_vld_s   = pick_s[PTR_W];
    assign grant_idx_s   = pick_s[PTR_W-1:0];
    assign req_idx_sel_s = req_idx_i[int'(grant_idx_s)*IDX_W +: IDX_W];
    assign bad_idx_s     = (req_idx_sel_s > IDX_W'(MAX_IDX));
    assign timeout_s     = (timer_r == TMR_W'(TIMEOUT_CYC - 1));
    assign rsp_fire_s    = rsp_ready_i[grant_r];

    // Next-state selection; a completion and a timeout in the same cycle both land in RESP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_s = bad_idx_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fib_ready_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (fib_done_i || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready_o = '0;
        fib_start_o = 1'b0;
        if ((state_r == ST_IDLE) && grant_vld_s) begin
            req_ready_o = onehot(grant_idx_s);
        end else begin
            req_ready_o = '0;
        end
        if ((state_r == ST_ISSUE) && fib_ready_i) begin
            fib_start_o = 1'b1;
        end else begin
            fib_start_o = 1'b0;
        end
    end

    // State register plus request latch, wait timer and response holding registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            idx_r       <= '0;
            timer_r     <= '0;
            rsp_valid_r <= '0;
            data_r      <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        grant_r <= grant_idx_s;
                        idx_r   <= req_idx_sel_s;
                        if (bad_idx_s) begin
                            data_r      <= '0;
                            err_r       <= 1'b1;
                            rsp_valid_r <= onehot(grant_idx_s);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (fib_ready_i) begin
                        timer_r <= '0;
                    end
                end
                ST_WAIT: begin
                    timer_r <= timer_r + TMR_W'(1);
                    if (fib_done_i) begin
                        data_r      <= fib_f_i;
                        err_r       <= 1'b0;
                        rsp_valid_r <= onehot(grant_r);
                    end else if (timeout_s) begin
                        data_r      <= '0;
                        err_r       <= 1'b1;
                        rsp_valid_r <= onehot(grant_r);
                    end
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp_valid_r <= '0;
                        rr_ptr_r    <= (grant_r == PTR_W'(N_REQ - 1)) ? '0 : grant_r + PTR_W'(1);
                    end
                end
                default: begin
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = data_r;
    assign rsp_err_o   = err_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign fib_idx_o   = idx_r;

endmodule

// File: tb/tb_fibonacci_arbiter.sv
// Directed self-checking bench for fibonacci_arbiter with a behavioural core model
// whose stall, latency and done behaviour are steered by the test tasks.
module tb_fibonacci_arbiter;

    localparam int N_REQ       = 4;
    localparam int IDX_W       = 5;
    localparam int DATA_W      = 20;
    localparam int MAX_IDX     = 30;
    localparam int TIMEOUT_CYC = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N_REQ*IDX_W-1:0] req_idx;
    logic [DATA_W-1:0]      rsp_data;
    logic [DATA_W-1:0]      fib_f = '0;
    logic                   rsp_err, busy, fib_start, fib_ready, fib_done;
    logic                   model_done = 1'b0;
    logic                   manual_done;
    logic [IDX_W-1:0]       fib_idx;
    logic [IDX_W-1:0]       core_idx = '0;
    logic [IDX_W-1:0]       last_start_idx = '0;

    int checks = 0;
    int passed = 0;
    int lat = 3;
    int stall = 0;
    bit done_en = 1'b1;
    int stall_cnt = 0;
    int cnt = 0;
    int start_cnt = 0;

    fibonacci_arbiter #(
        .N_REQ(N_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W),
        .MAX_IDX(MAX_IDX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_idx_i(req_idx), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
        .fib_start_o(fib_start), .fib_idx_o(fib_idx),
        .fib_ready_i(fib_ready), .fib_done_i(fib_done), .fib_f_i(fib_f)
    );

    always #5 clk = ~clk;

    function automatic int fib_ref(input int n);
        int a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    assign fib_ready = (stall_cnt == 0);
    assign fib_done  = model_done | manual_done;

    // Core model: not ready for 'stall' cycles after a fire, done 'lat' cycles after start.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (|(req_valid & req_ready)) stall_cnt <= stall;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
        if (fib_start) begin
            start_cnt      <= start_cnt + 1;
            last_start_idx <= fib_idx;
            core_idx       <= fib_idx;
            if (lat <= 1) begin
                model_done <= done_en;
                fib_f      <= DATA_W'(fib_ref(int'(fib_idx)));
                cnt        <= 0;
            end else begin
                cnt <= lat - 1;
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                model_done <= done_en;
                fib_f      <= DATA_W'(fib_ref(int'(core_idx)));
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; rsp_ready = '0; manual_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full request/response for requester k; lat_cyc counts cycles from fire to rsp_valid.
    task automatic transact(input int k, input logic [IDX_W-1:0] idx,
                            output logic [N_REQ-1:0] grant, output logic [N_REQ-1:0] vld,
                            output logic [DATA_W-1:0] data, output logic err, output int lat_cyc);
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[k] = 1'b1;
        req_idx[k*IDX_W +: IDX_W] = idx;
        @(negedge clk);
        grant = req_ready;
        @(posedge clk); #1;
        req_valid = '0;
        lat_cyc = 0;
        vld = '0;
        while (vld == '0 && lat_cyc < 300) begin
            @(negedge clk);
            lat_cyc++;
            vld = rsp_valid;
        end
        data = rsp_data;
        err  = rsp_err;
        @(posedge clk); #1 rsp_ready = vld;
        @(posedge clk); #1 rsp_ready = '0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; rsp_ready = '0; manual_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, busy, fib_start, fib_idx} !== '0)
            $display("FAIL reset_outputs: got ready=%b valid=%b data=%0d err=%b busy=%b start=%b idx=%0d expected all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, busy, fib_start, fib_idx);
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [N_REQ-1:0] g, v;
        logic [DATA_W-1:0] d;
        logic e;
        int lc, s0;
        lat = 3; stall = 0; done_en = 1'b1;
        s0 = start_cnt;
        transact(0, 5'd10, g, v, d, e, lc);
        checks++; if (g !== 4'b0001) $display("FAIL basic_grant: got %b expected 0001", g); else passed++;
        checks++; if (v !== 4'b0001) $display("FAIL basic_rsp_valid: got %b expected 0001", v); else passed++;
        checks++; if ({d, e} !== {20'd55, 1'b0}) $display("FAIL basic_data: got %0d err=%b expected 55 err=0", d, e); else passed++;
        checks++; if (lc !== 5) $display("FAIL basic_latency: got %0d expected 5", lc); else passed++;
        checks++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0); else passed++;
        checks++; if (last_start_idx !== 5'd10) $display("FAIL basic_start_idx: got %0d expected 10", last_start_idx); else passed++;
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] exp_g, vld;
        int n;
        apply_reset();
        for (int k = 0; k < N_REQ; k++) req_idx[k*IDX_W +: IDX_W] = IDX_W'(k + 1);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            @(negedge clk);
            checks++;
            if (req_ready !== exp_g) $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready, exp_g);
            else passed++;
            n = 0;
            vld = '0;
            while (vld == '0 && n < 300) begin
                @(negedge clk);
                n++;
                vld = rsp_valid;
            end
            checks++;
            if ({vld, rsp_data, rsp_err} !== {exp_g, DATA_W'(fib_ref(i % 4 + 1)), 1'b0})
                $display("FAIL rr_rsp_%0d: got valid=%b data=%0d err=%b expected valid=%b data=%0d err=0",
                         i, vld, rsp_data, rsp_err, exp_g, fib_ref(i % 4 + 1));
            else passed++;
            @(posedge clk); #1 rsp_ready = vld;
            @(posedge clk); #1 rsp_ready = '0;
        end
        req_valid = '0;
    endtask

    task automatic test_boundary();
        logic [N_REQ-1:0] g, v;
        logic [DATA_W-1:0] d;
        logic e;
        int lc, s0;
        stall = 3;
        transact(2, 5'd30, g, v, d, e, lc);
        stall = 0;
        checks++; if ({g, v} !== {4'b0100, 4'b0100}) $display("FAIL max_idx_grant: got grant=%b valid=%b expected 0100/0100", g, v); else passed++;
        checks++; if ({d, e} !== {20'd832040, 1'b0}) $display("FAIL max_idx_data: got %0d err=%b expected 832040 err=0", d, e); else passed++;
        checks++; if (lc !== 8) $display("FAIL stall_latency: got %0d expected 8", lc); else passed++;
        s0 = start_cnt;
        transact(3, 5'd31, g, v, d, e, lc);
        checks++; if (v !== 4'b1000) $display("FAIL bad_idx_valid: got %b expected 1000", v); else passed++;
        checks++; if ({d, e} !== {20'd0, 1'b1}) $display("FAIL bad_idx_data: got %0d err=%b expected 0 err=1", d, e); else passed++;
        checks++; if (lc !== 1) $display("FAIL bad_idx_latency: got %0d expected 1", lc); else passed++;
        checks++; if (start_cnt - s0 !== 0) $display("FAIL bad_idx_no_start: got %0d pulses expected 0", start_cnt - s0); else passed++;
    endtask

    task automatic test_timeout();
        logic [N_REQ-1:0] g, v;
        logic [DATA_W-1:0] d;
        logic e;
        int lc;
        done_en = 1'b0;
        transact(1, 5'd7, g, v, d, e, lc);
        done_en = 1'b1;
        checks++; if ({v, d, e} !== {4'b0010, 20'd0, 1'b1}) $display("FAIL timeout_rsp: got valid=%b data=%0d err=%b expected 0010/0/1", v, d, e); else passed++;
        // one cycle to start, TIMEOUT_CYC wait cycles, then the response
        checks++; if (lc !== TIMEOUT_CYC + 2) $display("FAIL timeout_latency: got %0d expected %0d", lc, TIMEOUT_CYC + 2); else passed++;
        lat = TIMEOUT_CYC;
        transact(1, 5'd7, g, v, d, e, lc);
        checks++; if ({v, d, e} !== {4'b0010, 20'd13, 1'b0}) $display("FAIL done_last_wait: got valid=%b data=%0d err=%b expected 0010/13/0", v, d, e); else passed++;
        checks++; if (lc !== TIMEOUT_CYC + 2) $display("FAIL done_last_latency: got %0d expected %0d", lc, TIMEOUT_CYC + 2); else passed++;
        lat = TIMEOUT_CYC + 1;
        transact(1, 5'd7, g, v, d, e, lc);
        checks++; if ({v, d, e} !== {4'b0010, 20'd0, 1'b1}) $display("FAIL done_too_late: got valid=%b data=%0d err=%b expected 0010/0/1", v, d, e); else passed++;
        lat = 3;
    endtask

    task automatic test_backpressure();
        logic [N_REQ-1:0] vld;
        int n;
        apply_reset();
        req_valid = 4'b0001;
        req_idx[0 +: IDX_W] = 5'd5;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_idx[IDX_W +: IDX_W] = 5'd6;
        rsp_ready = 4'b0010;
        n = 0;
        vld = '0;
        while (vld == '0 && n < 300) begin
            @(negedge clk);
            n++;
            vld = rsp_valid;
        end
        for (int j = 0; j < 10; j++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_err, req_ready} !== {4'b0001, 20'd5, 1'b0, 4'b0000})
                $display("FAIL hold_%0d: got valid=%b data=%0d err=%b ready=%b expected 0001/5/0/0000",
                         j, rsp_valid, rsp_data, rsp_err, req_ready);
            else passed++;
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 4'b0001;
        @(posedge clk); #1 rsp_ready = '0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) $display("FAIL after_consume_grant: got %b expected 0010", req_ready); else passed++;
        @(posedge clk); #1 req_valid = '0;
        n = 0;
        vld = '0;
        while (vld == '0 && n < 300) begin
            @(negedge clk);
            n++;
            vld = rsp_valid;
        end
        checks++;
        if ({vld, rsp_data, rsp_err} !== {4'b0010, 20'd8, 1'b0})
            $display("FAIL req1_rsp: got valid=%b data=%0d err=%b expected 0010/8/0", vld, rsp_data, rsp_err);
        else passed++;
        @(posedge clk); #1 rsp_ready = vld;
        @(posedge clk); #1 rsp_ready = '0;
    endtask

    task automatic test_reset_mid();
        logic [N_REQ-1:0] g, v;
        logic [DATA_W-1:0] d;
        logic e;
        int lc;
        done_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_idx[0 +: IDX_W] = 5'd9;
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL busy_before_reset: got %b expected 1", busy); else passed++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, rsp_err, rsp_data, fib_start, fib_idx, req_ready} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b valid=%b err=%b data=%0d start=%b idx=%0d ready=%b expected all 0",
                     busy, rsp_valid, rsp_err, rsp_data, fib_start, fib_idx, req_ready);
        else passed++;
        @(posedge clk); #1 manual_done = 1'b1;
        @(posedge clk); #1 manual_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== {1'b0, 4'b0000})
            $display("FAIL late_done_ignored: got busy=%b valid=%b expected 0/0000", busy, rsp_valid);
        else passed++;
        done_en = 1'b1;
        transact(0, 5'd10, g, v, d, e, lc);
        checks++;
        if ({g, v, d, e} !== {4'b0001, 4'b0001, 20'd55, 1'b0})
            $display("FAIL post_reset_req: got grant=%b valid=%b data=%0d err=%b expected 0001/0001/55/0", g, v, d, e);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_idx = '0;
        rsp_ready = '0;
        manual_done = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_boundary();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
